mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu.sv | 229 ++++++++++++++++++++++
 tb/tb_mem_lsu.sv | 275 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : mem_lsu
//  Purpose  : Load/store unit between an RV32 pipeline and a single-port RAM
//             with registered read data. One request is in flight at a time:
//             it is accepted in IDLE, checked for alignment and legality,
//             issued to the RAM as a single-cycle strobe, and the response
//             (sign/zero-extended load data or an error flag) is held until
//             the pipeline consumes it.
//
//  Ports    : clk, rst             clock, asynchronous active-high reset
//             req_*_i / req_ready_o  request handshake (we, funct3, addr, wdata)
//             resp_*_o / resp_ready_i response handshake (rdata, err)
//             ram_*_o / ram_q_i      RAM strobes, width code, address, data
//             stat_*_o             load/store/error event counters
//
//  Options  : LSU_STATS_EN  when defined, stat_* are live 32-bit wrapping
//                           counters; otherwise they are tied to zero.
//
//  Revision : 1.0  initial release
// ============================================================================
module mem_lsu #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    // request side
    input  logic                  req_valid_i,
    output logic                  req_ready_o,
    input  logic                  req_we_i,
    input  logic [2:0]            req_funct3_i,
    input  logic [ADDR_WIDTH-1:0] req_addr_i,
    input  logic [DATA_WIDTH-1:0] req_wdata_i,
    // response side
    output logic                  resp_valid_o,
    input  logic                  resp_ready_i,
    output logic [DATA_WIDTH-1:0] resp_rdata_o,
    output logic                  resp_err_o,
    // RAM side
    output logic [2:0]            ram_rwtyp_o,
    output logic [ADDR_WIDTH-1:0] ram_addr_o,
    output logic [DATA_WIDTH-1:0] ram_data_o,
    output logic                  ram_wren_o,
    output logic                  ram_rden_o,
    input  logic [DATA_WIDTH-1:0] ram_q_i,
    // statistics
    output logic [31:0]           stat_loads_o,
    output logic [31:0]           stat_stores_o,
    output logic [31:0]           stat_errs_o
);

    // RV32 funct3 width/sign codes
    localparam logic [2:0] c_f3_b  = 3'b000;
    localparam logic [2:0] c_f3_h  = 3'b001;
    localparam logic [2:0] c_f3_w  = 3'b010;
    localparam logic [2:0] c_f3_bu = 3'b100;
    localparam logic [2:0] c_f3_hu = 3'b101;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ISSUE   = 2'd1,
        CAPTURE = 2'd2,
        RESP    = 2'd3
    } state_t;

    state_t                  state_q;
    state_t                  state_d;

    logic                    we_q;
    logic [2:0]              funct3_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [DATA_WIDTH-1:0]   wdata_q;
    logic [DATA_WIDTH-1:0]   rdata_q;
    logic                    err_q;

    logic                    w_accept;
    logic                    w_req_err;
    logic [DATA_WIDTH-1:0]   w_ext_data;

    assign w_accept = req_valid_i && (state_q == IDLE);

    // ------------------------------------------------------------------------
    // Legality check on the live request. Unsigned widths are load-only, and
    // halfword/word accesses must be naturally aligned.
    // ------------------------------------------------------------------------
    always_comb begin
        w_req_err = 1'b0;
        case (req_funct3_i)
            c_f3_b:  w_req_err = 1'b0;
            c_f3_h:  w_req_err = req_addr_i[0];
            c_f3_w:  w_req_err = |req_addr_i[1:0];
            c_f3_bu: w_req_err = req_we_i;
            c_f3_hu: w_req_err = req_we_i | req_addr_i[0];
            default: w_req_err = 1'b1;
        endcase
    end

    // ------------------------------------------------------------------------
    // Load data extension. The RAM already zero-extends sub-word reads, so
    // only the sign-extending codes need to look at the top bit.
    // ------------------------------------------------------------------------
    always_comb begin
        w_ext_data = ram_q_i;
        case (funct3_q)
            c_f3_b:  w_ext_data = {{(DATA_WIDTH-8){ram_q_i[7]}},   ram_q_i[7:0]};
            c_f3_h:  w_ext_data = {{(DATA_WIDTH-16){ram_q_i[15]}}, ram_q_i[15:0]};
            c_f3_w:  w_ext_data = ram_q_i;
            c_f3_bu: w_ext_data = {{(DATA_WIDTH-8){1'b0}},         ram_q_i[7:0]};
            c_f3_hu: w_ext_data = {{(DATA_WIDTH-16){1'b0}},        ram_q_i[15:0]};
            default: w_ext_data = ram_q_i;
        endcase
    end

    // ------------------------------------------------------------------------
    // FSM state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------------
    // FSM next state and outputs. Strobes are decoded from the state so an
    // asynchronous reset during ISSUE drops them immediately.
    // ------------------------------------------------------------------------
    always_comb begin
        state_d      = state_q;
        req_ready_o  = 1'b0;
        resp_valid_o = 1'b0;
        ram_rden_o   = 1'b0;
        ram_wren_o   = 1'b0;
        case (state_q)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    state_d = w_req_err ? RESP : ISSUE;
                end
            end
            ISSUE: begin
                ram_rden_o = ~we_q;
                ram_wren_o = we_q;
                state_d    = we_q ? RESP : CAPTURE;
            end
            CAPTURE: begin
                state_d = RESP;
            end
            RESP: begin
                resp_valid_o = 1'b1;
                if (resp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Request and response registers. rdata_q is cleared at accept so stores
    // and errors respond with zero; only CAPTURE overwrites it.
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q     <= 1'b0;
            funct3_q <= c_f3_w;
            addr_q   <= '0;
            wdata_q  <= '0;
            rdata_q  <= '0;
            err_q    <= 1'b0;
        end else begin
            if (w_accept) begin
                we_q     <= req_we_i;
                funct3_q <= req_funct3_i;
                addr_q   <= req_addr_i;
                wdata_q  <= req_wdata_i;
                rdata_q  <= '0;
                err_q    <= w_req_err;
            end else if (state_q == CAPTURE) begin
                rdata_q  <= w_ext_data;
            end
        end
    end

    assign resp_rdata_o = rdata_q;
    assign resp_err_o   = err_q;
    assign ram_rwtyp_o  = {1'b0, funct3_q[1:0]};
    assign ram_addr_o   = addr_q;
    assign ram_data_o   = wdata_q;

    // ------------------------------------------------------------------------
    // Event counters, bumped once per accepted request.
    // ------------------------------------------------------------------------
`ifdef LSU_STATS_EN
    logic [31:0] loads_q;
    logic [31:0] stores_q;
    logic [31:0] errs_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            loads_q  <= '0;
            stores_q <= '0;
            errs_q   <= '0;
        end else if (w_accept) begin
            if (w_req_err) begin
                errs_q <= errs_q + 32'd1;
            end else if (req_we_i) begin
                stores_q <= stores_q + 32'd1;
            end else begin
                loads_q <= loads_q + 32'd1;
            end
        end
    end

    assign stat_loads_o  = loads_q;
    assign stat_stores_o = stores_q;
    assign stat_errs_o   = errs_q;
`else
    assign stat_loads_o  = 32'd0;
    assign stat_stores_o = 32'd0;
    assign stat_errs_o   = 32'd0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_mem_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_lsu
//  Purpose  : Directed self-checking bench for mem_lsu with a byte-addressed
//             RAM model (registered, zero-extending read data).
//  Revision : 1.0  initial release
// ============================================================================
module tb_mem_lsu;

    logic        clk;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_we;
    logic [2:0]  req_funct3;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic        resp_ready;
    logic [31:0] resp_rdata;
    logic        resp_err;
    logic [2:0]  ram_rwtyp;
    logic [31:0] ram_addr;
    logic [31:0] ram_data;
    logic        ram_wren;
    logic        ram_rden;
    logic [31:0] ram_q;
    logic [31:0] stat_loads;
    logic [31:0] stat_stores;
    logic [31:0] stat_errs;

    int n_total;
    int n_bad;
    int exp_loads;
    int exp_stores;
    int exp_errs;

    logic       mem_init;
    logic [7:0] mem [0:255];

    mem_lsu #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .clk           (clk),
        .rst           (rst),
        .req_valid_i   (req_valid),
        .req_ready_o   (req_ready),
        .req_we_i      (req_we),
        .req_funct3_i  (req_funct3),
        .req_addr_i    (req_addr),
        .req_wdata_i   (req_wdata),
        .resp_valid_o  (resp_valid),
        .resp_ready_i  (resp_ready),
        .resp_rdata_o  (resp_rdata),
        .resp_err_o    (resp_err),
        .ram_rwtyp_o   (ram_rwtyp),
        .ram_addr_o    (ram_addr),
        .ram_data_o    (ram_data),
        .ram_wren_o    (ram_wren),
        .ram_rden_o    (ram_rden),
        .ram_q_i       (ram_q),
        .stat_loads_o  (stat_loads),
        .stat_stores_o (stat_stores),
        .stat_errs_o   (stat_errs)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ------------------------------------------------------------------------
    // RAM model
    // ------------------------------------------------------------------------
    function automatic logic [31:0] ram_read(input logic [2:0] t, input logic [7:0] a);
        logic [7:0] a1;
        logic [7:0] a2;
        logic [7:0] a3;
        a1 = a + 8'd1;
        a2 = a + 8'd2;
        a3 = a + 8'd3;
        case (t)
            3'b000:  ram_read = {24'd0, mem[a]};
            3'b001:  ram_read = {16'd0, mem[a1], mem[a]};
            default: ram_read = {mem[a3], mem[a2], mem[a1], mem[a]};
        endcase
    endfunction

    always @(posedge clk) begin
        if (mem_init) begin
            for (int i = 0; i < 256; i++) mem[i] <= 8'h00;
            mem[8'h10] <= 8'hF0;               // word 0x10 = 0x000000F0
            mem[8'h30] <= 8'h01;               // word 0x30 = 0x00008001
            mem[8'h31] <= 8'h80;
        end else if (ram_wren) begin
            mem[ram_addr[7:0]] <= ram_data[7:0];
            if (ram_rwtyp != 3'b000) mem[ram_addr[7:0] + 8'd1] <= ram_data[15:8];
            if (ram_rwtyp == 3'b010) begin
                mem[ram_addr[7:0] + 8'd2] <= ram_data[23:16];
                mem[ram_addr[7:0] + 8'd3] <= ram_data[31:24];
            end
        end
        ram_q <= ram_rden ? ram_read(ram_rwtyp, ram_addr[7:0]) : 32'd0;
    end

    // ------------------------------------------------------------------------
    // Checking
    // ------------------------------------------------------------------------
    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    // One full transaction: drive, watch strobes and latency, check response,
    // optionally stall resp_ready for 'hold' cycles, then release.
    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [31:0] exp_rd,
                          input logic exp_err, input int exp_lat,
                          input logic [2:0] exp_rwtyp, input int hold);
        int         lat;
        int         nrd;
        int         nwr;
        logic       got;
        logic [2:0] seen_typ;
        logic [31:0] seen_addr;
        logic [31:0] seen_data;
        lat = 1; nrd = 0; nwr = 0; got = 1'b0;
        seen_typ = 3'b111; seen_addr = 32'hFFFF_FFFF; seen_data = 32'hFFFF_FFFF;

        @(negedge clk);
        check_eq("req_ready_idle", {31'd0, req_ready}, 32'd1);
        req_valid = 1'b1; req_we = we; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
        resp_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        // scramble inputs: the latched request must not follow them
        req_valid = 1'b0; req_we = ~we; req_funct3 = 3'b111;
        req_addr = 32'hFFFF_FFFF; req_wdata = 32'h5555_5555;

        if (exp_err) exp_errs++;
        else if (we) exp_stores++;
        else exp_loads++;

        while (!got && lat <= 8) begin
            nrd += int'(ram_rden);
            nwr += int'(ram_wren);
            if (ram_rden || ram_wren) begin
                seen_typ = ram_rwtyp; seen_addr = ram_addr; seen_data = ram_data;
            end
            if (resp_valid) got = 1'b1;
            else begin
                @(negedge clk);
                lat++;
            end
        end
        if (!got) begin
            check_eq("resp_timeout", 32'd0, 32'd1);
        end else begin
            check_eq("latency", lat, exp_lat);
            check_eq("resp_rdata", resp_rdata, exp_rd);
            check_eq("resp_err", {31'd0, resp_err}, {31'd0, exp_err});
            check_eq("rden_pulses", nrd, (!exp_err && !we) ? 32'd1 : 32'd0);
            check_eq("wren_pulses", nwr, (!exp_err && we) ? 32'd1 : 32'd0);
            if (!exp_err) begin
                check_eq("ram_rwtyp", {29'd0, seen_typ}, {29'd0, exp_rwtyp});
                check_eq("ram_addr", seen_addr, addr);
                if (we) check_eq("ram_data", seen_data, wdata);
            end
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check_eq("stall_valid", {31'd0, resp_valid}, 32'd1);
                check_eq("stall_rdata", resp_rdata, exp_rd);
                check_eq("stall_ready", {31'd0, req_ready}, 32'd0);
                check_eq("stall_strobe", {30'd0, ram_rden, ram_wren}, 32'd0);
            end
            resp_ready = 1'b1;
            @(negedge clk);
            resp_ready = 1'b0;
            check_eq("back_to_idle", {30'd0, resp_valid, req_ready}, 32'd1);
        end
    endtask

    task automatic check_stats(input string tag);
`ifdef LSU_STATS_EN
        check_eq({tag, "_loads"},  stat_loads,  exp_loads);
        check_eq({tag, "_stores"}, stat_stores, exp_stores);
        check_eq({tag, "_errs"},   stat_errs,   exp_errs);
`else
        check_eq({tag, "_loads"},  stat_loads,  32'd0);
        check_eq({tag, "_stores"}, stat_stores, 32'd0);
        check_eq({tag, "_errs"},   stat_errs,   32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        n_total = 0; n_bad = 0;
        exp_loads = 0; exp_stores = 0; exp_errs = 0;
        rst = 1'b1; mem_init = 1'b1;
        req_valid = 1'b0; req_we = 1'b0; req_funct3 = 3'b000;
        req_addr = 32'd0; req_wdata = 32'd0; resp_ready = 1'b0;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_ready",  {31'd0, req_ready}, 32'd1);
        check_eq("rst_valid",  {31'd0, resp_valid}, 32'd0);
        check_eq("rst_err",    {31'd0, resp_err}, 32'd0);
        check_eq("rst_rdata",  resp_rdata, 32'd0);
        check_eq("rst_rwtyp",  {29'd0, ram_rwtyp}, 32'd2);
        check_eq("rst_addr",   ram_addr, 32'd0);
        check_eq("rst_data",   ram_data, 32'd0);
        check_eq("rst_strobe", {30'd0, ram_rden, ram_wren}, 32'd0);
        check_stats("rst");
        mem_init = 1'b0;
        rst = 1'b0;

        //      we    f3      addr        wdata         exp_rd        err  lat typ     hold
        do_req(1'b0, 3'b000, 32'h10, 32'h0,         32'hFFFF_FFF0, 1'b0, 3, 3'b000, 0); // LB
        do_req(1'b0, 3'b100, 32'h10, 32'h0,         32'h0000_00F0, 1'b0, 3, 3'b000, 0); // LBU
        do_req(1'b0, 3'b101, 32'h30, 32'h0,         32'h0000_8001, 1'b0, 3, 3'b001, 0); // LHU
        do_req(1'b0, 3'b001, 32'h30, 32'h0,         32'hFFFF_8001, 1'b0, 3, 3'b001, 0); // LH
        do_req(1'b1, 3'b010, 32'h20, 32'hDEAD_BEEF, 32'h0,         1'b0, 2, 3'b010, 0); // SW
        do_req(1'b0, 3'b010, 32'h20, 32'h0,         32'hDEAD_BEEF, 1'b0, 3, 3'b010, 0); // LW
        do_req(1'b0, 3'b010, 32'h22, 32'h0,         32'h0,         1'b1, 1, 3'b010, 0); // LW misaligned
        do_req(1'b1, 3'b001, 32'h21, 32'h1234_5678, 32'h0,         1'b1, 1, 3'b001, 0); // SH misaligned
        do_req(1'b0, 3'b011, 32'h20, 32'h0,         32'h0,         1'b1, 1, 3'b011, 0); // illegal funct3
        do_req(1'b1, 3'b100, 32'h20, 32'h0,         32'h0,         1'b1, 1, 3'b000, 0); // unsigned store
        do_req(1'b1, 3'b000, 32'h41, 32'h1234_56AB, 32'h0,         1'b0, 2, 3'b000, 0); // SB
        do_req(1'b0, 3'b010, 32'h40, 32'h0,         32'h0000_AB00, 1'b0, 3, 3'b010, 0); // LW after SB
        do_req(1'b0, 3'b010, 32'h20, 32'h0,         32'hDEAD_BEEF, 1'b0, 3, 3'b010, 5); // stalled response
        check_stats("run");

        // Reset in the middle of a load's ISSUE cycle
        @(negedge clk);
        req_valid = 1'b1; req_we = 1'b0; req_funct3 = 3'b010; req_addr = 32'h20;
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        check_eq("abort_rden_before", {31'd0, ram_rden}, 32'd1);
        #2 rst = 1'b1;
        #1;
        check_eq("abort_rden_after", {31'd0, ram_rden}, 32'd0);
        check_eq("abort_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        rst = 1'b0;
        exp_loads = 0; exp_stores = 0; exp_errs = 0;
        resp_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check_eq("abort_no_resp", {31'd0, resp_valid}, 32'd0);
        end
        resp_ready = 1'b0;
        check_stats("abort");

        // 3 loads + 1 store + 1 error after reset
        do_req(1'b0, 3'b010, 32'h20, 32'h0,         32'hDEAD_BEEF, 1'b0, 3, 3'b010, 0);
        do_req(1'b0, 3'b100, 32'h10, 32'h0,         32'h0000_00F0, 1'b0, 3, 3'b000, 0);
        do_req(1'b0, 3'b001, 32'h30, 32'h0,         32'hFFFF_8001, 1'b0, 3, 3'b001, 0);
        do_req(1'b1, 3'b010, 32'h24, 32'h0102_0304, 32'h0,         1'b0, 2, 3'b010, 0);
        do_req(1'b0, 3'b001, 32'h23, 32'h0,         32'h0,         1'b1, 1, 3'b001, 0);
        check_stats("final");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
